// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the fft4_elastic radix-4 butterfly:
//   - FFT_FWD / FFT_INV : values of the i_inverse mode bit
//   - cplx_w            : width of a packed complex word {real, imag}
//   - fft_quant         : arithmetic right shift (optional round half-up),
//                         then saturation to a signed output width; reports
//                         whether the value was clamped
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam logic FFT_FWD = 1'b0;
  localparam logic FFT_INV = 1'b1;

  // Working width for quantisation; wide enough that the rounding add can
  // never overflow for any realistic component width.
  localparam int QW = 32;

  function automatic int cplx_w(input int nb);
    return 2 * nb;
  endfunction

  function automatic logic signed [QW-1:0] fft_quant(
    input  logic signed [QW-1:0] i_x,
    input  int                   i_d,
    input  int                   i_nb_out,
    input  logic                 i_rnd,
    output logic                 o_clamp
  );
    logic signed [QW-1:0] v_t;
    logic signed [QW-1:0] v_one;
    logic signed [QW-1:0] v_hi;
    logic signed [QW-1:0] v_lo;
    v_one   = 1;
    v_t     = i_x;
    o_clamp = 1'b0;
    if (i_rnd && (i_d > 0)) begin
      v_t = v_t + (v_one <<< (i_d - 1));
    end
    v_t  = v_t >>> i_d;
    v_hi = (v_one <<< (i_nb_out - 1)) - v_one;
    v_lo = -v_hi - v_one;
    if (v_t > v_hi) begin
      v_t     = v_hi;
      o_clamp = 1'b1;
    end else if (v_t < v_lo) begin
      v_t     = v_lo;
      o_clamp = 1'b1;
    end
    return v_t;
  endfunction

endpackage

// File: rtl/fft4_quant.sv
// ---------------------------------------------------------------------------
// fft4_quant
// Per-component quantiser: discards D_BASE + i_shift LSBs (floor, or round
// half-up when FFT4_ROUND_EN is defined) and saturates to NB_OUT bits.
// Configuration macro: FFT4_ROUND_EN (defined = round half-up, else floor).
// Ports:
//   i_x      in   NB_IN   signed component from the butterfly
//   i_shift  in   2       extra right shift for this vector
//   o_q      out  NB_OUT  quantised, saturated component
//   o_clamp  out  1       saturation was applied
// ---------------------------------------------------------------------------
module fft4_quant
  import fft_pkg::*;
#(
  parameter int NB_IN  = 10,
  parameter int NB_OUT = 10,
  parameter int D_BASE = 0
) (
  input  logic signed [NB_IN-1:0]  i_x,
  input  logic        [1:0]        i_shift,
  output logic signed [NB_OUT-1:0] o_q,
  output logic                     o_clamp
);

`ifdef FFT4_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  logic signed [QW-1:0] w_q;
  logic                 w_clamp;
  logic                 w_unused_hi;

  always_comb begin
    w_clamp = 1'b0;
    w_q     = fft_quant(QW'(i_x), D_BASE + int'(i_shift), NB_OUT, ROUND_EN, w_clamp);
  end

  // After saturation the upper bits are pure sign extension.
  assign o_q         = w_q[NB_OUT-1:0];
  assign o_clamp     = w_clamp;
  assign w_unused_hi = ^w_q[QW-1:NB_OUT];

endmodule

// File: rtl/fft4_elastic.sv
// ---------------------------------------------------------------------------
// fft4_elastic
// Radix-4 DIT butterfly, 4 complex samples in / 4 complex bins out per
// transfer, 3-stage pipeline with valid/ready back-pressure, runtime
// forward/inverse, per-vector right-shift scaling and sticky saturation flag.
// Configuration macro: FFT4_ROUND_EN (see fft4_quant); port list identical.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_x0..i_x3          complex inputs {real, imag}, NB_INPUT each
//   i_valid / o_ready   input handshake
//   i_inverse, i_shift  mode and scaling, travel with the vector
//   i_clr_sat           clears o_sat (wins over a same-cycle set)
//   o_x0..o_x3          complex outputs {real, imag}, NB_OUTPUT each
//   o_valid / i_ready   output handshake
//   o_sat               sticky: a transferred-out component was clamped
// ---------------------------------------------------------------------------
module fft4_elastic
  import fft_pkg::*;
#(
  parameter int NB_INPUT   = 8,
  parameter int NBF_INPUT  = 7,
  parameter int NB_OUTPUT  = 10,
  parameter int NBF_OUTPUT = 7
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [cplx_w(NB_INPUT)-1:0]    i_x0,
  input  logic [cplx_w(NB_INPUT)-1:0]    i_x1,
  input  logic [cplx_w(NB_INPUT)-1:0]    i_x2,
  input  logic [cplx_w(NB_INPUT)-1:0]    i_x3,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_inverse,
  input  logic [1:0]                     i_shift,
  input  logic                           i_clr_sat,
  output logic [cplx_w(NB_OUTPUT)-1:0]   o_x0,
  output logic [cplx_w(NB_OUTPUT)-1:0]   o_x1,
  output logic [cplx_w(NB_OUTPUT)-1:0]   o_x2,
  output logic [cplx_w(NB_OUTPUT)-1:0]   o_x3,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_sat
);

  localparam int NB_S2  = NB_INPUT + 1;
  localparam int NB_S3  = NB_INPUT + 2;
  localparam int D_BASE = NBF_INPUT - NBF_OUTPUT;

  logic                        w_adv;
  logic signed [NB_INPUT-1:0]  w_a_re [4];
  logic signed [NB_INPUT-1:0]  w_a_im [4];
  logic signed [NB_INPUT-1:0]  r_s1_re [4];
  logic signed [NB_INPUT-1:0]  r_s1_im [4];
  logic                        r_v1;
  logic                        r_s1_inv;
  logic [1:0]                  r_s1_shift;
  // S2 slots: 0 = e0, 1 = e1, 2 = p, 3 = d
  logic signed [NB_S2-1:0]     r_s2_re [4];
  logic signed [NB_S2-1:0]     r_s2_im [4];
  logic                        r_v2;
  logic                        r_s2_inv;
  logic [1:0]                  r_s2_shift;
  logic signed [NB_S3-1:0]     w_rot_re;
  logic signed [NB_S3-1:0]     w_rot_im;
  logic signed [NB_S3-1:0]     w_x_re [4];
  logic signed [NB_S3-1:0]     w_x_im [4];
  logic signed [NB_OUTPUT-1:0] w_q_re [4];
  logic signed [NB_OUTPUT-1:0] w_q_im [4];
  logic [3:0]                  w_clamp_re;
  logic [3:0]                  w_clamp_im;
  logic signed [NB_OUTPUT-1:0] r_o_re [4];
  logic signed [NB_OUTPUT-1:0] r_o_im [4];
  logic                        r_v3;
  logic                        r_clamp3;
  logic                        r_sat;

  // All stages move together, so one enable covers the whole pipe.
  assign w_adv   = !r_v3 || i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_v3;
  assign o_sat   = r_sat;

  assign w_a_re[0] = i_x0[2*NB_INPUT-1:NB_INPUT];
  assign w_a_im[0] = i_x0[NB_INPUT-1:0];
  assign w_a_re[1] = i_x1[2*NB_INPUT-1:NB_INPUT];
  assign w_a_im[1] = i_x1[NB_INPUT-1:0];
  assign w_a_re[2] = i_x2[2*NB_INPUT-1:NB_INPUT];
  assign w_a_im[2] = i_x2[NB_INPUT-1:0];
  assign w_a_re[3] = i_x3[2*NB_INPUT-1:NB_INPUT];
  assign w_a_im[3] = i_x3[NB_INPUT-1:0];

  // Data registers of S1/S2 need no reset: their valids qualify them.
  always_ff @(posedge i_clk) begin
    if (w_adv) begin
      r_s1_re    <= w_a_re;
      r_s1_im    <= w_a_im;
      r_s1_inv   <= i_inverse;
      r_s1_shift <= i_shift;
      r_s2_re[0] <= NB_S2'(r_s1_re[0]) + NB_S2'(r_s1_re[2]);
      r_s2_im[0] <= NB_S2'(r_s1_im[0]) + NB_S2'(r_s1_im[2]);
      r_s2_re[1] <= NB_S2'(r_s1_re[0]) - NB_S2'(r_s1_re[2]);
      r_s2_im[1] <= NB_S2'(r_s1_im[0]) - NB_S2'(r_s1_im[2]);
      r_s2_re[2] <= NB_S2'(r_s1_re[1]) + NB_S2'(r_s1_re[3]);
      r_s2_im[2] <= NB_S2'(r_s1_im[1]) + NB_S2'(r_s1_im[3]);
      r_s2_re[3] <= NB_S2'(r_s1_re[1]) - NB_S2'(r_s1_re[3]);
      r_s2_im[3] <= NB_S2'(r_s1_im[1]) - NB_S2'(r_s1_im[3]);
      r_s2_inv   <= r_s1_inv;
      r_s2_shift <= r_s1_shift;
    end
  end

  // rot = -j*d (forward) = (d_im, -d_re); +j*d (inverse) = (-d_im, d_re)
  always_comb begin
    w_rot_re = NB_S3'(r_s2_im[3]);
    w_rot_im = -NB_S3'(r_s2_re[3]);
    if (r_s2_inv == FFT_INV) begin
      w_rot_re = -NB_S3'(r_s2_im[3]);
      w_rot_im = NB_S3'(r_s2_re[3]);
    end
    w_x_re[0] = NB_S3'(r_s2_re[0]) + NB_S3'(r_s2_re[2]);
    w_x_im[0] = NB_S3'(r_s2_im[0]) + NB_S3'(r_s2_im[2]);
    w_x_re[2] = NB_S3'(r_s2_re[0]) - NB_S3'(r_s2_re[2]);
    w_x_im[2] = NB_S3'(r_s2_im[0]) - NB_S3'(r_s2_im[2]);
    w_x_re[1] = NB_S3'(r_s2_re[1]) + w_rot_re;
    w_x_im[1] = NB_S3'(r_s2_im[1]) + w_rot_im;
    w_x_re[3] = NB_S3'(r_s2_re[1]) - w_rot_re;
    w_x_im[3] = NB_S3'(r_s2_im[1]) - w_rot_im;
  end

  for (genvar k = 0; k < 4; k++) begin : g_bin
    fft4_quant #(.NB_IN(NB_S3), .NB_OUT(NB_OUTPUT), .D_BASE(D_BASE)) u_q_re (
      .i_x     (w_x_re[k]),
      .i_shift (r_s2_shift),
      .o_q     (w_q_re[k]),
      .o_clamp (w_clamp_re[k])
    );
    fft4_quant #(.NB_IN(NB_S3), .NB_OUT(NB_OUTPUT), .D_BASE(D_BASE)) u_q_im (
      .i_x     (w_x_im[k]),
      .i_shift (r_s2_shift),
      .o_q     (w_q_im[k]),
      .o_clamp (w_clamp_im[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_clamp3 <= 1'b0;
      r_sat    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_o_re[k] <= '0;
        r_o_im[k] <= '0;
      end
    end else begin
      if (w_adv) begin
        r_v1     <= i_valid;
        r_v2     <= r_v1;
        r_v3     <= r_v2;
        r_o_re   <= w_q_re;
        r_o_im   <= w_q_im;
        r_clamp3 <= |{w_clamp_re, w_clamp_im};
      end
      // Only a vector actually handed downstream may set the flag.
      if (i_clr_sat) begin
        r_sat <= 1'b0;
      end else if (r_v3 && i_ready && r_clamp3) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign o_x0 = {r_o_re[0], r_o_im[0]};
  assign o_x1 = {r_o_re[1], r_o_im[1]};
  assign o_x2 = {r_o_re[2], r_o_im[2]};
  assign o_x3 = {r_o_re[3], r_o_im[3]};

endmodule

// File: tb/tb_fft4_elastic.sv
// ---------------------------------------------------------------------------
// tb_fft4_elastic
// Directed bench for fft4_elastic. Two instances share all inputs: the
// default build (NB_OUTPUT=10) and a narrow one (NB_OUTPUT=9) that can clamp.
// Expected values follow the FFT4_ROUND_EN build setting.
// ---------------------------------------------------------------------------
module tb_fft4_elastic;

`ifdef FFT4_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_x0, i_x1, i_x2, i_x3;
  logic        i_valid, i_inverse, i_clr_sat, i_ready;
  logic [1:0]  i_shift;
  logic [19:0] o_x0, o_x1, o_x2, o_x3;
  logic        o_ready, o_valid, o_sat;
  logic [17:0] n_x0, n_x1, n_x2, n_x3;
  logic        n_ready, n_valid, n_sat;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  fft4_elastic dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_x0(i_x0), .i_x1(i_x1), .i_x2(i_x2), .i_x3(i_x3),
    .i_valid(i_valid), .o_ready(o_ready), .i_inverse(i_inverse),
    .i_shift(i_shift), .i_clr_sat(i_clr_sat),
    .o_x0(o_x0), .o_x1(o_x1), .o_x2(o_x2), .o_x3(o_x3),
    .o_valid(o_valid), .i_ready(i_ready), .o_sat(o_sat)
  );

  fft4_elastic #(.NB_OUTPUT(9)) dut9 (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_x0(i_x0), .i_x1(i_x1), .i_x2(i_x2), .i_x3(i_x3),
    .i_valid(i_valid), .o_ready(n_ready), .i_inverse(i_inverse),
    .i_shift(i_shift), .i_clr_sat(i_clr_sat),
    .o_x0(n_x0), .o_x1(n_x1), .o_x2(n_x2), .o_x3(n_x3),
    .o_valid(n_valid), .i_ready(i_ready), .o_sat(n_sat)
  );

  function automatic logic [19:0] c10(input int re, input int im);
    return {10'(re), 10'(im)};
  endfunction

  function automatic logic [17:0] c9(input int re, input int im);
    return {9'(re), 9'(im)};
  endfunction

  task automatic drive_vec(input int r0, input int m0, input int r1, input int m1,
                           input int r2, input int m2, input int r3, input int m3,
                           input logic inv, input logic [1:0] sh);
    i_x0 = {8'(r0), 8'(m0)};
    i_x1 = {8'(r1), 8'(m1)};
    i_x2 = {8'(r2), 8'(m2)};
    i_x3 = {8'(r3), 8'(m3)};
    i_inverse = inv;
    i_shift   = sh;
    i_valid   = 1'b1;
  endtask

  // Accept the driven vector, then wait (bounded) for o_valid.
  // lat = cycles from the accept cycle to o_valid, or -1 on timeout.
  task automatic push_wait(output int lat);
    lat = 0;
    do begin
      @(negedge i_clk);
      i_valid = 1'b0;
      lat++;
    end while (!o_valid && lat < 10);
    if (!o_valid) lat = -1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_clr_sat = 1'b0;
    i_inverse = 1'b0; i_shift = 2'd0;
    i_x0 = '0; i_x1 = '0; i_x2 = '0; i_x3 = '0;
    repeat (2) @(negedge i_clk);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    n_chk++; if (o_x0 !== 20'd0) begin n_fail++; $display("FAIL reset_x0 got=%h exp=0", o_x0); end
    n_chk++; if (o_x3 !== 20'd0) begin n_fail++; $display("FAIL reset_x3 got=%h exp=0", o_x3); end
    n_chk++; if (o_sat !== 1'b0 || n_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got=%b/%b exp=0/0", o_sat, n_sat); end
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_impulse;
    int lat;
    drive_vec(64, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd0);
    push_wait(lat);
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL impulse_latency got=%0d exp=3", lat); end
    n_chk++; if (o_x0 !== c10(64, 0)) begin n_fail++; $display("FAIL impulse_x0 got=%h exp=%h", o_x0, c10(64, 0)); end
    n_chk++; if (o_x1 !== c10(64, 0)) begin n_fail++; $display("FAIL impulse_x1 got=%h exp=%h", o_x1, c10(64, 0)); end
    n_chk++; if (o_x2 !== c10(64, 0)) begin n_fail++; $display("FAIL impulse_x2 got=%h exp=%h", o_x2, c10(64, 0)); end
    n_chk++; if (o_x3 !== c10(64, 0)) begin n_fail++; $display("FAIL impulse_x3 got=%h exp=%h", o_x3, c10(64, 0)); end
  endtask

  task automatic test_forward;
    int lat;
    drive_vec(0, 0, 64, 0, 0, 0, 0, 0, 1'b0, 2'd0);
    push_wait(lat);
    n_chk++; if (o_x0 !== c10(64, 0))  begin n_fail++; $display("FAIL fwd_x0 got=%h exp=%h", o_x0, c10(64, 0)); end
    n_chk++; if (o_x1 !== c10(0, -64)) begin n_fail++; $display("FAIL fwd_x1 got=%h exp=%h", o_x1, c10(0, -64)); end
    n_chk++; if (o_x2 !== c10(-64, 0)) begin n_fail++; $display("FAIL fwd_x2 got=%h exp=%h", o_x2, c10(-64, 0)); end
    n_chk++; if (o_x3 !== c10(0, 64))  begin n_fail++; $display("FAIL fwd_x3 got=%h exp=%h", o_x3, c10(0, 64)); end
  endtask

  task automatic test_inverse;
    int lat;
    drive_vec(0, 0, 64, 0, 0, 0, 0, 0, 1'b1, 2'd0);
    push_wait(lat);
    n_chk++; if (o_x0 !== c10(64, 0))  begin n_fail++; $display("FAIL inv_x0 got=%h exp=%h", o_x0, c10(64, 0)); end
    n_chk++; if (o_x1 !== c10(0, 64))  begin n_fail++; $display("FAIL inv_x1 got=%h exp=%h", o_x1, c10(0, 64)); end
    n_chk++; if (o_x2 !== c10(-64, 0)) begin n_fail++; $display("FAIL inv_x2 got=%h exp=%h", o_x2, c10(-64, 0)); end
    n_chk++; if (o_x3 !== c10(0, -64)) begin n_fail++; $display("FAIL inv_x3 got=%h exp=%h", o_x3, c10(0, -64)); end
  endtask

  // a0=(10,20) a1=(30,-40) a2=(-5,6) a3=(7,8)
  task automatic test_mixed;
    int lat;
    drive_vec(10, 20, 30, -40, -5, 6, 7, 8, 1'b0, 2'd0);
    push_wait(lat);
    n_chk++; if (o_x0 !== c10(42, -6))  begin n_fail++; $display("FAIL mixed_x0 got=%h exp=%h", o_x0, c10(42, -6)); end
    n_chk++; if (o_x1 !== c10(-33, -9)) begin n_fail++; $display("FAIL mixed_x1 got=%h exp=%h", o_x1, c10(-33, -9)); end
    n_chk++; if (o_x2 !== c10(-32, 58)) begin n_fail++; $display("FAIL mixed_x2 got=%h exp=%h", o_x2, c10(-32, 58)); end
    n_chk++; if (o_x3 !== c10(63, 37))  begin n_fail++; $display("FAIL mixed_x3 got=%h exp=%h", o_x3, c10(63, 37)); end
  endtask

  task automatic test_shift;
    int lat;
    logic [19:0] e0, e1;
    e0 = RND ? c10(11, -1) : c10(10, -2);
    e1 = RND ? c10(-8, -2) : c10(-9, -3);
    drive_vec(10, 20, 30, -40, -5, 6, 7, 8, 1'b0, 2'd2);
    push_wait(lat);
    n_chk++; if (o_x0 !== e0) begin n_fail++; $display("FAIL shift2_x0 got=%h exp=%h", o_x0, e0); end
    n_chk++; if (o_x1 !== e1) begin n_fail++; $display("FAIL shift2_x1 got=%h exp=%h", o_x1, e1); end
  endtask

  task automatic test_rounding;
    int lat;
    logic [19:0] ep, en;
    ep = RND ? c10(2, 0) : c10(1, 0);
    en = RND ? c10(-1, 0) : c10(-2, 0);
    drive_vec(3, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd1);
    push_wait(lat);
    n_chk++; if (o_x0 !== ep) begin n_fail++; $display("FAIL round_pos got=%h exp=%h", o_x0, ep); end
    drive_vec(-3, 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd1);
    push_wait(lat);
    n_chk++; if (o_x0 !== en) begin n_fail++; $display("FAIL round_neg got=%h exp=%h", o_x0, en); end
  endtask

  task automatic test_saturate;
    int lat;
    drive_vec(127, 0, 127, 0, 127, 0, 127, 0, 1'b0, 2'd0);
    push_wait(lat);
    n_chk++; if (n_x0 !== c9(255, 0)) begin n_fail++; $display("FAIL sat_x0_9b got=%h exp=%h", n_x0, c9(255, 0)); end
    n_chk++; if (n_x1 !== c9(0, 0)) begin n_fail++; $display("FAIL sat_x1_9b got=%h exp=%h", n_x1, c9(0, 0)); end
    n_chk++; if (o_x0 !== c10(508, 0)) begin n_fail++; $display("FAIL sat_x0_10b got=%h exp=%h", o_x0, c10(508, 0)); end
    n_chk++; if (n_sat !== 1'b0) begin n_fail++; $display("FAIL sat_before_xfer got=%b exp=0", n_sat); end
    @(negedge i_clk);
    n_chk++; if (n_sat !== 1'b1) begin n_fail++; $display("FAIL sat_set got=%b exp=1", n_sat); end
    n_chk++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL sat_10b_clear got=%b exp=0", o_sat); end
  endtask

  task automatic test_clr_sat;
    int lat;
    i_clr_sat = 1'b1;
    @(negedge i_clk);
    i_clr_sat = 1'b0;
    n_chk++; if (n_sat !== 1'b0) begin n_fail++; $display("FAIL clr_sat got=%b exp=0", n_sat); end
    @(negedge i_clk);
    n_chk++; if (n_sat !== 1'b0) begin n_fail++; $display("FAIL clr_sat_hold got=%b exp=0", n_sat); end
    // clear in the same cycle as a clamping transfer must win
    drive_vec(127, 0, 127, 0, 127, 0, 127, 0, 1'b0, 2'd0);
    push_wait(lat);
    i_clr_sat = 1'b1;
    @(negedge i_clk);
    i_clr_sat = 1'b0;
    n_chk++; if (n_sat !== 1'b0) begin n_fail++; $display("FAIL clr_priority got=%b exp=0", n_sat); end
    @(negedge i_clk);
    n_chk++; if (n_sat !== 1'b0) begin n_fail++; $display("FAIL clr_priority_hold got=%b exp=0", n_sat); end
  endtask

  task automatic test_back_to_back;
    int sent, got;
    logic acc, holding;
    logic [19:0] hold;
    sent = 0; got = 0; holding = 1'b0; hold = '0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      i_ready = !(cyc >= 4 && cyc < 8);
      if (sent < 5) drive_vec(10 * (sent + 1), sent + 1, 0, 0, 0, 0, 0, 0, 1'b0, 2'd0);
      else i_valid = 1'b0;
      #1;
      if (o_valid && !i_ready) begin
        n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", cyc, o_ready); end
        if (holding) begin
          n_chk++; if (o_x0 !== hold) begin n_fail++; $display("FAIL stall_stable cyc=%0d got=%h exp=%h", cyc, o_x0, hold); end
        end
        hold = o_x0; holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (o_valid && i_ready) begin
        n_chk++; if (o_x0 !== c10(10 * (got + 1), got + 1)) begin
          n_fail++; $display("FAIL stream_order idx=%0d got=%h exp=%h", got, o_x0, c10(10 * (got + 1), got + 1));
        end
        got++;
      end
      acc = i_valid && o_ready;
      @(negedge i_clk);
      if (acc) sent++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    n_chk++; if (got !== 5) begin n_fail++; $display("FAIL stream_count got=%0d exp=5", got); end
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_extra k=%0d got=%b exp=0", k, o_valid); end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset_midflight;
    int lat;
    drive_vec(127, 0, 127, 0, 127, 0, 127, 0, 1'b0, 2'd0);
    push_wait(lat);
    @(negedge i_clk);
    n_chk++; if (n_sat !== 1'b1) begin n_fail++; $display("FAIL pre_reset_sat got=%b exp=1", n_sat); end
    for (int k = 0; k < 3; k++) begin
      drive_vec(5 * (k + 1), 0, 0, 0, 0, 0, 0, 0, 1'b0, 2'd0);
      @(negedge i_clk);
    end
    n_chk++; if (o_valid !== 1'b1 || o_x0 !== c10(5, 0)) begin
      n_fail++; $display("FAIL pre_reset_out got=%b/%h exp=1/%h", o_valid, o_x0, c10(5, 0));
    end
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b exp=0", o_valid); end
    n_chk++; if (o_x0 !== 20'd0 || o_x2 !== 20'd0) begin n_fail++; $display("FAIL mid_reset_data got=%h/%h exp=0/0", o_x0, o_x2); end
    n_chk++; if (n_sat !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sat got=%b exp=0", n_sat); end
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stale_after_reset k=%0d got=%b exp=0", k, o_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_forward();
    test_inverse();
    test_mixed();
    test_shift();
    test_rounding();
    test_saturate();
    test_clr_sat();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
